// File: rtl/warp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler_pkg
// Description : Kernel descriptor, idle descriptor and per-core state encoding
// Revision    : 1.0
// ============================================================================
package warp_scheduler_pkg;

    typedef struct packed {
        logic [3:0]  warp_id;
        logic [7:0]  thread_count;
        logic [31:0] start_pc;
    } kernel_t;

    // Driven onto a core's kernel_in whenever it has no warp assigned
    localparam kernel_t IDLE_KERNEL = '{warp_id: 4'hF, thread_count: 8'd0, start_pc: 32'd0};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISPATCH  = 2'd1,
        RUN       = 2'd2,
        DONE_PEND = 2'd3
    } core_state_e;

endpackage
`default_nettype wire

// File: rtl/warp_scheduler_launch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler_launch_fifo
// Description : Synchronous FIFO of kernel launches with occupancy count
// Revision    : 1.0
// ============================================================================
module warp_scheduler_launch_fifo
    import warp_scheduler_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  kernel_t                i_data,
    input  logic                   i_pop,
    output kernel_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    kernel_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_push;

    // Full is a function of the registered count only, so a pop in the
    // same cycle never makes room for a push into a full queue.
    assign o_full  = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler
// Description : Queues kernel launches, dispatches round-robin to idle SIMD
//               cores, reports completions. Option: WARP_SCHED_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int QUEUE_DEPTH    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        launch_valid,
    output logic                                        launch_ready,
    input  kernel_t                                     launch_kernel,
    output kernel_t [NUM_CORES-1:0]                     core_kernel,
    output logic    [NUM_CORES-1:0]                     core_start,
    input  logic    [NUM_CORES-1:0]                     core_finished,
    input  logic    [NUM_CORES-1:0][3:0]                core_finished_warp_id,
    output logic                                        done_valid,
    output logic    [3:0]                               done_warp_id,
    output logic    [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] done_core,
`ifdef WARP_SCHED_TIMEOUT_EN
    output logic                                        done_timeout,
`endif
    output logic    [$clog2(QUEUE_DEPTH):0]             queue_count,
    output logic                                        busy,
    output logic                                        err_zero_thread,
    output logic                                        err_id_mismatch
);

    localparam int c_CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    kernel_t               w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_zero_head;
    logic                  w_dispatch;
    logic                  w_pop;
    logic                  w_sel_valid;
    logic                  w_rep_valid;
    logic [c_CORE_W-1:0]   w_sel_idx;
    logic [c_CORE_W-1:0]   w_rep_idx;
    logic [c_CORE_W-1:0]   w_cand;
    logic [c_CORE_W-1:0]   r_rr;
    logic [NUM_CORES-1:0]  w_idle;
    logic [NUM_CORES-1:0]  w_pend;
    logic [NUM_CORES-1:0]  w_sel_vec;
    logic [NUM_CORES-1:0]  w_grant_vec;
    logic [NUM_CORES-1:0]  w_mismatch;
`ifdef WARP_SCHED_TIMEOUT_EN
    logic [NUM_CORES-1:0]  w_timed_out;
`endif

    warp_scheduler_launch_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_launch_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (launch_valid),
        .i_data  (launch_kernel),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queue_count)
    );

    assign launch_ready = !w_full;

    // First idle core at or after the round-robin pointer
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_cand = c_CORE_W'((int'(r_rr) + k) % NUM_CORES);
            if (!w_sel_valid && w_idle[w_cand]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    // A zero-thread head is discarded and uses up this cycle's single pop
    assign w_zero_head = !w_empty && (w_head.thread_count == '0);
    assign w_dispatch  = !w_empty && !w_zero_head && w_sel_valid;
    assign w_pop       = w_zero_head || w_dispatch;
    assign w_sel_vec   = w_dispatch ? (NUM_CORES'(1) << w_sel_idx) : '0;

    always_comb begin
        w_rep_valid = 1'b0;
        w_rep_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_rep_valid = 1'b1;
                w_rep_idx   = c_CORE_W'(i);
            end
        end
    end

    assign w_grant_vec = w_rep_valid ? (NUM_CORES'(1) << w_rep_idx) : '0;
    assign busy        = !w_empty || !(&w_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr            <= '0;
            done_valid      <= 1'b0;
            done_warp_id    <= '0;
            done_core       <= '0;
            err_zero_thread <= 1'b0;
            err_id_mismatch <= 1'b0;
`ifdef WARP_SCHED_TIMEOUT_EN
            done_timeout    <= 1'b0;
`endif
        end else begin
            if (w_dispatch) begin
                r_rr <= (w_sel_idx == c_CORE_W'(NUM_CORES - 1)) ? '0 : w_sel_idx + c_CORE_W'(1);
            end
            done_valid <= w_rep_valid;
            if (w_rep_valid) begin
                done_warp_id <= core_kernel[w_rep_idx].warp_id;
                done_core    <= w_rep_idx;
            end
`ifdef WARP_SCHED_TIMEOUT_EN
            done_timeout <= w_rep_valid && w_timed_out[w_rep_idx];
`endif
            err_zero_thread <= err_zero_thread | w_zero_head;
            err_id_mismatch <= err_id_mismatch | (|w_mismatch);
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_state_e r_state;
        core_state_e w_state_next;
        kernel_t     r_kernel;
        logic        r_first_run;
        logic        w_finish;
        logic        w_run_end;

        // The core's finish flag is not trusted in its first RUN cycle
        assign w_finish      = (r_state == RUN) && !r_first_run && core_finished[i];
        assign w_mismatch[i] = w_finish && (core_finished_warp_id[i] != r_kernel.warp_id);
        assign w_idle[i]     = (r_state == IDLE);
        assign w_pend[i]     = (r_state == DONE_PEND);
        assign core_start[i] = (r_state == DISPATCH);
        assign core_kernel[i] = r_kernel;

`ifdef WARP_SCHED_TIMEOUT_EN
        localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [c_TMR_W-1:0] r_timer;
        logic               r_timeout;
        logic               w_expire;

        assign w_expire       = (r_state == RUN) && (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));
        assign w_run_end      = w_finish || w_expire;
        assign w_timed_out[i] = r_timeout;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_timer   <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == DISPATCH) begin
                r_timer   <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == RUN) begin
                r_timer <= r_timer + c_TMR_W'(1);
                if (w_expire && !w_finish) begin
                    r_timeout <= 1'b1;
                end
            end
        end
`else
        assign w_run_end = w_finish;
`endif

        always_comb begin
            w_state_next = r_state;
            case (r_state)
                IDLE:      if (w_sel_vec[i]) w_state_next = DISPATCH;
                DISPATCH:  w_state_next = RUN;
                RUN:       if (w_run_end) w_state_next = DONE_PEND;
                DONE_PEND: if (w_grant_vec[i]) w_state_next = IDLE;
                default:   w_state_next = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state     <= IDLE;
                r_kernel    <= IDLE_KERNEL;
                r_first_run <= 1'b0;
            end else begin
                r_state     <= w_state_next;
                r_first_run <= (r_state == DISPATCH);
                if (w_sel_vec[i]) begin
                    r_kernel <= w_head;
                end else if (w_pend[i] && w_grant_vec[i]) begin
                    r_kernel <= IDLE_KERNEL;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_scheduler
// Description : Directed self-checking bench for warp_scheduler (2 cores, depth 8)
// Revision    : 1.0
// ============================================================================
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                launch_valid;
    logic                launch_ready;
    kernel_t             launch_kernel;
    kernel_t [1:0]       core_kernel;
    logic    [1:0]       core_start;
    logic    [1:0]       core_finished;
    logic    [1:0][3:0]  core_finished_warp_id;
    logic                done_valid;
    logic    [3:0]       done_warp_id;
    logic    [0:0]       done_core;
    logic    [3:0]       queue_count;
    logic                busy;
    logic                err_zero_thread;
    logic                err_id_mismatch;
`ifdef WARP_SCHED_TIMEOUT_EN
    logic                done_timeout;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    warp_scheduler #(
        .NUM_CORES      (2),
        .QUEUE_DEPTH    (8),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .launch_valid          (launch_valid),
        .launch_ready          (launch_ready),
        .launch_kernel         (launch_kernel),
        .core_kernel           (core_kernel),
        .core_start            (core_start),
        .core_finished         (core_finished),
        .core_finished_warp_id (core_finished_warp_id),
        .done_valid            (done_valid),
        .done_warp_id          (done_warp_id),
        .done_core             (done_core),
`ifdef WARP_SCHED_TIMEOUT_EN
        .done_timeout          (done_timeout),
`endif
        .queue_count           (queue_count),
        .busy                  (busy),
        .err_zero_thread       (err_zero_thread),
        .err_id_mismatch       (err_id_mismatch)
    );

    function automatic kernel_t mk(input logic [3:0] id, input logic [7:0] thr, input logic [31:0] pc);
        kernel_t k;
        k.warp_id      = id;
        k.thread_count = thr;
        k.start_pc     = pc;
        return k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                   = 1'b1;
        launch_valid          = 1'b0;
        launch_kernel         = '0;
        core_finished         = '0;
        core_finished_warp_id = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic finish_core(input int c, input logic [3:0] id);
        core_finished[c]         = 1'b1;
        core_finished_warp_id[c] = id;
    endtask

    initial begin
        // ---------------- single launch ----------------
        do_reset();
        check("rst_ready",   64'(launch_ready), 64'd1);
        check("rst_qcount",  64'(queue_count), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_start",   64'(core_start), 64'd0);
        check("rst_done",    64'(done_valid), 64'd0);
        check("rst_doneid",  64'(done_warp_id), 64'd0);
        check("rst_k0",      64'(core_kernel[0]), 64'(IDLE_KERNEL));
        check("rst_k1",      64'(core_kernel[1]), 64'(IDLE_KERNEL));
        check("rst_errs",    64'({err_zero_thread, err_id_mismatch}), 64'd0);

        launch_valid  = 1'b1;
        launch_kernel = mk(4'd1, 8'd4, 32'h12345678);
        step();
        launch_valid = 1'b0;
        check("t1_qc_push",  64'(queue_count), 64'd1);
        check("t1_nostart",  64'(core_start), 64'd0);
        step();
        check("t1_start",    64'(core_start), 64'b01);
        check("t1_kernel",   64'(core_kernel[0]), 64'(mk(4'd1, 8'd4, 32'h12345678)));
        check("t1_qc_pop",   64'(queue_count), 64'd0);
        step();
        check("t1_pulse",    64'(core_start), 64'd0);
        repeat (3) step();
        check("t1_hold",     64'(core_kernel[0]), 64'(mk(4'd1, 8'd4, 32'h12345678)));
        check("t1_busy",     64'(busy), 64'd1);
        finish_core(0, 4'd1);
        step();
        core_finished = '0;
        check("t1_done_lat", 64'(done_valid), 64'd0);
        step();
        check("t1_done",     64'(done_valid), 64'd1);
        check("t1_done_id",  64'(done_warp_id), 64'd1);
        check("t1_done_c",   64'(done_core), 64'd0);
        check("t1_k0_idle",  64'(core_kernel[0].warp_id), 64'hF);
        check("t1_idle",     64'(busy), 64'd0);
        step();
        check("t1_done_1cy", 64'(done_valid), 64'd0);

        // ---------------- four back-to-back launches ----------------
        do_reset();
        launch_valid  = 1'b1;
        launch_kernel = mk(4'd1, 8'd4, 32'h100);
        step();
        check("t2_qc1",      64'(queue_count), 64'd1);
        launch_kernel = mk(4'd2, 8'd4, 32'h200);
        step();
        check("t2_start0",   64'(core_start), 64'b01);
        check("t2_k0",       64'(core_kernel[0].warp_id), 64'd1);
        launch_kernel = mk(4'd3, 8'd4, 32'h300);
        step();
        check("t2_start1",   64'(core_start), 64'b10);
        check("t2_k1",       64'(core_kernel[1].warp_id), 64'd2);
        launch_kernel = mk(4'd4, 8'd4, 32'h400);
        step();
        launch_valid = 1'b0;
        check("t2_qc_peak",  64'(queue_count), 64'd2);
        check("t2_nostart",  64'(core_start), 64'd0);
        step();
        finish_core(1, 4'd2);
        step();
        core_finished = '0;
        step();
        check("t2_done_c1",  64'({done_valid, done_core, done_warp_id}), 64'({1'b1, 1'b1, 4'd2}));
        step();
        check("t2_redisp1",  64'(core_start), 64'b10);
        check("t2_k1_id3",   64'(core_kernel[1].warp_id), 64'd3);
        check("t2_qc_after", 64'(queue_count), 64'd1);
        finish_core(0, 4'd1);
        step();
        core_finished = '0;
        step();
        check("t2_done_c0",  64'({done_valid, done_core, done_warp_id}), 64'({1'b1, 1'b0, 4'd1}));
        step();
        check("t2_redisp0",  64'(core_start), 64'b01);
        check("t2_k0_id4",   64'(core_kernel[0].warp_id), 64'd4);
        check("t2_qc_empty", 64'(queue_count), 64'd0);

        // ---------------- fill the queue ----------------
        do_reset();
        launch_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            launch_kernel = mk(4'(i), 8'd4, 32'(i));
            step();
            if (i == 9) begin
                check("t3_qc9",    64'(queue_count), 64'd7);
                check("t3_rdy9",   64'(launch_ready), 64'd1);
            end
        end
        check("t3_qc_full",  64'(queue_count), 64'd8);
        check("t3_not_rdy",  64'(launch_ready), 64'd0);
        launch_kernel = mk(4'd11, 8'd4, 32'd11);
        step();
        step();
        check("t3_refused",  64'(queue_count), 64'd8);
        finish_core(0, 4'd1);
        step();
        core_finished = '0;
        step();
        check("t3_done",     64'({done_valid, done_warp_id}), 64'({1'b1, 4'd1}));
        check("t3_qc_hold",  64'(queue_count), 64'd8);
        step();
        check("t3_disp3",    64'(core_kernel[0].warp_id), 64'd3);
        check("t3_popfull",  64'(queue_count), 64'd7);
        check("t3_rdy_back", 64'(launch_ready), 64'd1);
        step();
        launch_valid = 1'b0;
        check("t3_accept11", 64'(queue_count), 64'd8);
        check("t3_full2",    64'(launch_ready), 64'd0);

        // ---------------- simultaneous finishes ----------------
        do_reset();
        launch_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            launch_kernel = mk(4'(i), 8'd8, 32'h40 * i);
            step();
        end
        launch_valid = 1'b0;
        step();
        step();
        finish_core(0, 4'd1);
        finish_core(1, 4'd2);
        step();
        core_finished = '0;
        check("t4_nodone",   64'(done_valid), 64'd0);
        step();
        check("t4_rep0",     64'({done_valid, done_core, done_warp_id}), 64'({1'b1, 1'b0, 4'd1}));
        check("t4_no_early", 64'(core_start), 64'd0);
        check("t4_qc_wait",  64'(queue_count), 64'd1);
        step();
        check("t4_rep1",     64'({done_valid, done_core, done_warp_id}), 64'({1'b1, 1'b1, 4'd2}));
        check("t4_redisp",   64'(core_start), 64'b01);
        check("t4_k0_id3",   64'(core_kernel[0].warp_id), 64'd3);
        step();
        check("t4_rep_end",  64'(done_valid), 64'd0);

        // ---------------- zero-thread launch ----------------
        do_reset();
        launch_valid  = 1'b1;
        launch_kernel = mk(4'd6, 8'd0, 32'h0);
        step();
        launch_kernel = mk(4'd7, 8'd4, 32'h700);
        step();
        launch_valid = 1'b0;
        check("t5_nostart",  64'(core_start), 64'd0);
        check("t5_err_zero", 64'(err_zero_thread), 64'd1);
        check("t5_qc",       64'(queue_count), 64'd1);
        step();
        check("t5_start",    64'(core_start), 64'b01);
        check("t5_k0_id7",   64'(core_kernel[0].warp_id), 64'd7);

        // ---------------- id mismatch and reset mid-run ----------------
        do_reset();
        launch_valid  = 1'b1;
        launch_kernel = mk(4'd2, 8'd4, 32'h222);
        step();
        launch_valid = 1'b0;
        step();
        repeat (3) step();
        check("t6_err_pre",  64'(err_id_mismatch), 64'd0);
        finish_core(0, 4'd5);
        step();
        core_finished = '0;
        check("t6_err_id",   64'(err_id_mismatch), 64'd1);
        step();
        check("t6_done_id",  64'({done_valid, done_warp_id}), 64'({1'b1, 4'd2}));
        launch_valid  = 1'b1;
        launch_kernel = mk(4'd3, 8'd4, 32'h333);
        step();
        launch_valid = 1'b0;
        step();
        check("t6_rr_core1", 64'(core_start), 64'b10);
        repeat (3) step();
        rst = 1'b1;
        finish_core(1, 4'd3);
        step();
        rst = 1'b0;
        check("t6_rst_done", 64'(done_valid), 64'd0);
        check("t6_rst_errs", 64'({err_zero_thread, err_id_mismatch}), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_k1",   64'(core_kernel[1]), 64'(IDLE_KERNEL));
        check("t6_rst_rdy",  64'(launch_ready), 64'd1);
        step();
        core_finished = '0;
        check("t6_no_rep1",  64'(done_valid), 64'd0);
        step();
        check("t6_no_rep2",  64'(done_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
